// File: rtl/cpu5_mc_ctrl.sv
// cpu5_mc_ctrl: multicycle main control FSM with memory handshake, illegal-opcode trap and retire counter
module cpu5_mc_ctrl #(
  parameter int OP_W = 6,
  parameter int ALUOP_W = 2,
  parameter int CNT_W = 16,
  parameter logic [OP_W-1:0] OP_RTYPE = 6'b000000,
  parameter logic [OP_W-1:0] OP_LW = 6'b100011,
  parameter logic [OP_W-1:0] OP_SW = 6'b101011,
  parameter logic [OP_W-1:0] OP_BEQ = 6'b000100,
  parameter logic [OP_W-1:0] OP_ADDI = 6'b001000,
  parameter logic [OP_W-1:0] OP_J = 6'b000010
) (
  input  logic clk,
  input  logic reset,
  input  logic [OP_W-1:0] op,
  input  logic mem_ready,
  output logic mem_req,
  output logic iord,
  output logic memwrite,
  output logic irwrite,
  output logic pcwrite,
  output logic branch,
  output logic regdst,
  output logic memtoreg,
  output logic regwrite,
  output logic alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic illegal_op,
  output logic instr_retired,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0] state
);
  localparam logic [3:0] S_FETCH = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4;
  localparam logic [3:0] S_MEMWR = 4'd5;
  localparam logic [3:0] S_EXEC = 4'd6;
  localparam logic [3:0] S_ALUWB = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;
  logic [3:0] next_state;
  logic [1:0] aluop2;
  logic ret;
  always_ff @(posedge clk)
    if (reset) state <= S_FETCH;
    else state <= next_state;
  always_ff @(posedge clk)
    if (reset) retired_cnt <= '0;
    else if (instr_retired) retired_cnt <= retired_cnt + 1'b1;
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: next_state = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                             (op == OP_RTYPE) ? S_EXEC :
                             (op == OP_BEQ) ? S_BRANCH :
                             (op == OP_ADDI) ? S_ADDIEX :
                             (op == OP_J) ? S_JUMP : S_ILLEGAL;
      S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end
  // enables are computed per state, then all write/request strobes are masked while reset is high
  always_comb begin
    mem_req = 1'b0;
    iord = 1'b0;
    memwrite = 1'b0;
    irwrite = 1'b0;
    pcwrite = 1'b0;
    branch = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    aluop2 = 2'b00;
    illegal_op = 1'b0;
    ret = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        ret = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        iord = 1'b1;
        memwrite = 1'b1;
        ret = mem_ready;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop2 = 2'b10;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst = 1'b1;
        ret = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop2 = 2'b01;
        pcsrc = 2'b01;
        branch = 1'b1;
        ret = 1'b1;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        ret = 1'b1;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
        ret = 1'b1;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      memwrite = 1'b0;
      irwrite = 1'b0;
      pcwrite = 1'b0;
      branch = 1'b0;
      regwrite = 1'b0;
      illegal_op = 1'b0;
      ret = 1'b0;
    end
    instr_retired = ret;
    aluop = ALUOP_W'(aluop2);
  end
endmodule

// File: doc/cpu5_mc_ctrl.md
Name: cpu5_mc_ctrl

Overview:
- Multicycle main control unit for the cpu5 core; replaces single-cycle opcode decoding with a Moore/Mealy FSM.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives datapath mux selects and write enables.
- Adds a memory request/ready handshake, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register (op input) and the multicycle datapath.

Parameters:
- OP_W, 6, opcode width; must be >= 6.
- ALUOP_W, 2, aluop width; upper bits beyond [1:0] are driven 0.
- CNT_W, 16, retired-instruction counter width.
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load opcode.
- OP_SW, 6'b101011, store opcode.
- OP_BEQ, 6'b000100, branch-equal opcode.
- OP_ADDI, 6'b001000, add-immediate opcode.
- OP_J, 6'b000010, jump opcode.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  OP_W  opcode from the instruction register; stable from DECODE until the next FETCH.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  address mux: 0=PC, 1=ALUOut.
- memwrite  out  1  store strobe; only valid with mem_req.
- irwrite  out  1  instruction register load.
- pcwrite  out  1  unconditional PC load.
- branch  out  1  conditional PC load (datapath ANDs with zero).
- regdst  out  1  0=rt, 1=rd.
- memtoreg  out  1  writeback data: 0=ALUOut, 1=MDR.
- regwrite  out  1  register file write.
- alusrca  out  1  0=PC, 1=rs.
- alusrcb  out  2  00=rt, 01=const 4, 10=signimm, 11=signimm<<2.
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- aluop  out  ALUOP_W  00=add, 01=sub, 10=funct-decoded.
- illegal_op  out  1  one-cycle pulse on undecodable opcode.
- instr_retired  out  1  one-cycle pulse when an instruction completes.
- retired_cnt  out  CNT_W  count of retired instructions.
- state  out  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12; codes 13-15 go to FETCH.
- Reset (sampled at posedge clk): state<=FETCH, retired_cnt<=0.
- While reset is high, mem_req, memwrite, irwrite, pcwrite, branch, regwrite, illegal_op and instr_retired are forced 0.
- All outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready. mem_ready=1 -> DECODE, else hold.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state: lw/sw->MEMADR; rtype->EXEC; beq->BRANCH; addi->ADDIEX; j->JUMP; any other opcode->ILLEGAL.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. op==OP_LW -> MEMRD, else MEMWR.
- MEMRD: mem_req=1, iord=1. mem_ready=1 -> MEMWB, else hold.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH; retires.
- MEMWR: mem_req=1, iord=1, memwrite=1. mem_ready=1 -> FETCH and retires, else hold with memwrite held high.
- EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH; retires.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH; retires.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH; retires.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH; retires.
- ILLEGAL: illegal_op=1 for exactly one cycle -> FETCH; does not retire; no register or memory write.
- instr_retired: combinational, high in the final cycle of a retiring instruction (MEMWR only when mem_ready=1). retired_cnt increments on the same edge and wraps from all-ones to 0.
- Latency with mem_ready tied 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Each cycle mem_ready is low adds 1 cycle in FETCH/MEMRD/MEMWR.
- Reset mid-instruction: abandons the instruction on the next edge with no retire and no count change.

Test Plan:
- Reset, mem_ready=1, op=100011 -> state 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; retired_cnt=1.
- op=101011, mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles; instr_retired only on the final cycle; no regwrite.
- op=000000 then 000100 -> R-type: aluop=10 in EXEC, regdst=1 in ALUWB. beq: pcsrc=01, branch=1, aluop=01 in state 8. Total 7 cycles, retired_cnt=2.
- op=111111 -> states 0,1,12,0; illegal_op pulse width 1; retired_cnt unchanged; no write enables.
- Assert reset while in state 3 -> next state 0; all enables 0 during reset; retired_cnt=0.
- CNT_W=2, run 5 j instructions -> retired_cnt sequence 1,2,3,0,1; each j takes 3 cycles with pcwrite=1 and pcsrc=10 in state 11.
